mem_store_ctrl: RTL and testbench

- Store-side requester to the data SRAM. It is the write-direction counterpart of the MEM-stage load extraction path.
- Accepts a store from EX: op, address and register data.
- Produces byte-lane-aligned data_sram request signals: req, wen, addr, wdata.
- Holds the request until the SRAM side accepts it, stalls the pipeline while waiting, and flags misaligned addresses and SRAM timeouts.

---
 rtl/mem_store_ctrl.sv | 88 ++++++++
 tb/tb_mem_store_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: store-side data SRAM requester with lane mapping, stall, misalign and timeout flags
module mem_store_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  input  logic [1:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             data_sram_req,
  output logic [3:0]       data_sram_wen,
  output logic [31:0]      data_sram_addr,
  output logic [31:0]      data_sram_wdata,
  input  logic             data_sram_addr_ok,
  output logic             stall_req,
  output logic             ades,
  output logic [31:0]      bad_vaddr,
  output logic             bus_err,
  output logic [CNT_W-1:0] store_cnt
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t           state_q, state_d;
  logic             req_q, req_d, ades_q, ades_d, bus_err_q, bus_err_d;
  logic [3:0]       wen_q, wen_d, wen_new;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, wdata_new, bad_vaddr_q, bad_vaddr_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  logic [1:0]       a;
  logic             mis, legal, done, tmo, free, acc, drop;
  always_comb begin
    a           = st_addr[1:0];
    mis         = st_valid && ((st_op == 2'b10 && a[0]) || (st_op == 2'b11 && a != 2'b00));
    legal       = st_valid && st_op != 2'b00 && !mis;
    done        = state_q == S_WAIT && data_sram_addr_ok;
    tmo         = state_q == S_WAIT && !data_sram_addr_ok && wait_cnt_q == 8'(MAX_WAIT - 1);
    free        = state_q == S_IDLE || done;
    acc         = legal && free;
    drop        = done || tmo;
    wen_new     = st_op == 2'b01 ? 4'b0001 << a : st_op == 2'b10 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_new   = st_op == 2'b01 ? {4{st_data[7:0]}} : st_op == 2'b10 ? {2{st_data[15:0]}} : st_data;
    state_d     = acc ? S_WAIT : drop ? S_IDLE : state_q;
    req_d       = acc ? 1'b1 : drop ? 1'b0 : req_q;
    wen_d       = acc ? wen_new : drop ? 4'b0 : wen_q;
    addr_d      = acc ? {st_addr[31:2], 2'b00} : drop ? 32'b0 : addr_q;
    wdata_d     = acc ? wdata_new : drop ? 32'b0 : wdata_q;
    wait_cnt_d  = (acc || drop) ? 8'd0 : state_q == S_WAIT ? wait_cnt_q + 8'd1 : wait_cnt_q;
    ades_d      = mis && free;
    bad_vaddr_d = (mis && free) ? st_addr : bad_vaddr_q;
    bus_err_d   = tmo;
    store_cnt_d = store_cnt_q + CNT_W'(done);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      wen_q       <= 4'b0;
      addr_q      <= 32'b0;
      wdata_q     <= 32'b0;
      wait_cnt_q  <= 8'd0;
      ades_q      <= 1'b0;
      bad_vaddr_q <= 32'b0;
      bus_err_q   <= 1'b0;
      store_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      ades_q      <= ades_d;
      bad_vaddr_q <= bad_vaddr_d;
      bus_err_q   <= bus_err_d;
      store_cnt_q <= store_cnt_d;
    end
  end
  assign data_sram_req   = req_q;
  assign data_sram_wen   = wen_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;
  assign stall_req       = state_q == S_WAIT && !data_sram_addr_ok;
  assign ades            = ades_q;
  assign bad_vaddr       = bad_vaddr_q;
  assign bus_err         = bus_err_q;
  assign store_cnt       = store_cnt_q;
endmodule

// File: tb/tb_mem_store_ctrl.sv
// tb_mem_store_ctrl: directed plan steps plus random traffic against a byte-lane reference model
module tb_mem_store_ctrl;
  localparam int MW = 16;
  logic        clk = 1'b0, rst = 1'b1;
  logic        st_valid = 1'b0, addr_ok = 1'b0;
  logic [1:0]  st_op = 2'b00;
  logic [31:0] st_addr = 32'b0, st_data = 32'b0;
  logic        req, stall_req, ades, bus_err;
  logic [3:0]  wen;
  logic [31:0] addr, wdata, bad_vaddr;
  logic [15:0] store_cnt;
  int total = 0, bad = 0;
  logic        m_req = 1'b0, m_ades = 1'b0, m_err = 1'b0;
  logic [3:0]  m_wen = 4'b0;
  logic [31:0] m_addr = 32'b0, m_wdata = 32'b0, m_bad = 32'b0;
  logic [15:0] m_cnt = 16'b0;
  int          m_wait = 0;

  mem_store_ctrl #(.MAX_WAIT(MW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr),
    .st_data(st_data), .data_sram_req(req), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok), .stall_req(stall_req),
    .ades(ades), .bad_vaddr(bad_vaddr), .bus_err(bus_err), .store_cnt(store_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected lanes come from access size: bytes a..a+sz-1 enabled, data repeated every sz bytes.
  task automatic cyc(input logic v, input logic [1:0] op, input logic [31:0] ad, input logic [31:0] d, input logic ok);
    int sz, a;
    logic mis, legal, free, done, tmo;
    logic [3:0] w;
    logic [31:0] wd;
    st_valid = v; st_op = op; st_addr = ad; st_data = d; addr_ok = ok;
    #1;
    chk("stall_req", 32'(stall_req), 32'(m_req && !ok));
    sz = op == 2'b01 ? 1 : op == 2'b10 ? 2 : 4;
    a = int'(ad[1:0]);
    mis = v && op != 2'b00 && (a % sz) != 0;
    legal = v && op != 2'b00 && !mis;
    done = m_req && ok;
    tmo = m_req && !ok && m_wait == MW - 1;
    free = !m_req || ok;
    for (int i = 0; i < 4; i++) begin
      w[i] = i >= a && i < a + sz;
      wd[8*i +: 8] = d[8*(i % sz) +: 8];
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_req = 0; m_wen = 0; m_addr = 0; m_wdata = 0; m_bad = 0;
      m_ades = 0; m_err = 0; m_cnt = 0; m_wait = 0;
    end else begin
      m_ades = mis && free;
      if (m_ades) m_bad = ad;
      m_err = tmo;
      if (done) m_cnt = m_cnt + 16'd1;
      if (legal && free) begin
        m_req = 1; m_wen = w; m_addr = {ad[31:2], 2'b00}; m_wdata = wd; m_wait = 0;
      end else if (done || tmo) begin
        m_req = 0; m_wen = 0; m_addr = 0; m_wdata = 0; m_wait = 0;
      end else if (m_req) m_wait++;
    end
    chk("req", 32'(req), 32'(m_req));
    chk("wen", 32'(wen), 32'(m_wen));
    chk("addr", addr, m_addr);
    chk("wdata", wdata, m_wdata);
    chk("ades", 32'(ades), 32'(m_ades));
    if (m_ades) chk("bad_vaddr", bad_vaddr, m_bad);
    chk("bus_err", 32'(bus_err), 32'(m_err));
    chk("store_cnt", 32'(store_cnt), 32'(m_cnt));
  endtask

  initial begin
    int n;
    cyc(0, 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 1);
    rst = 0;
    chk("rst_cnt", 32'(store_cnt), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    cyc(1, 2'b01, 32'h0000_1003, 32'h1234_56AB, 0);
    chk("sb_wen", 32'(wen), 32'h8);
    chk("sb_addr", addr, 32'h0000_1000);
    chk("sb_wdata", wdata, 32'hABAB_ABAB);
    cyc(0, 2'b00, 0, 0, 1);
    chk("sb_cnt", 32'(store_cnt), 32'd1);
    cyc(1, 2'b10, 32'h0000_2001, 32'h0000_5555, 0);
    chk("sh_mis_ades", 32'(ades), 32'd1);
    chk("sh_mis_bad", bad_vaddr, 32'h0000_2001);
    chk("sh_mis_req", 32'(req), 32'd0);
    cyc(0, 2'b00, 0, 0, 0);
    chk("sh_mis_pulse", 32'(ades), 32'd0);
    cyc(1, 2'b11, 32'h0000_3000, 32'hDEAD_BEEF, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 2'b00, 0, 0, 0);
      chk("sw_hold_wdata", wdata, 32'hDEAD_BEEF);
    end
    cyc(0, 2'b00, 0, 0, 1);
    chk("sw_cnt", 32'(store_cnt), 32'd2);
    cyc(1, 2'b10, 32'h0000_4002, 32'h0000_CAFE, 0);
    chk("b2b_wen1", 32'(wen), 32'hC);
    chk("b2b_wdata1", wdata, 32'hCAFE_CAFE);
    cyc(1, 2'b10, 32'h0000_4000, 32'h0000_1234, 1);
    chk("b2b_req", 32'(req), 32'd1);
    chk("b2b_wen2", 32'(wen), 32'h3);
    chk("b2b_wdata2", wdata, 32'h1234_1234);
    cyc(0, 2'b00, 0, 0, 1);
    chk("b2b_cnt", 32'(store_cnt), 32'd4);
    cyc(1, 2'b11, 32'h0000_5000, 32'h0BAD_F00D, 0);
    n = 0;
    for (int k = 0; k < 20 && req; k++) begin
      n++;
      cyc(0, 2'b00, 0, 0, 0);
    end
    chk("tmo_req_cycles", 32'(n), 32'(MW));
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    cyc(0, 2'b00, 0, 0, 0);
    chk("tmo_pulse", 32'(bus_err), 32'd0);
    chk("tmo_cnt", 32'(store_cnt), 32'd4);
    cyc(1, 2'b11, 32'h0000_6000, 32'h1111_2222, 0);
    cyc(0, 2'b00, 0, 0, 0);
    rst = 1;
    cyc(0, 2'b00, 0, 0, 0);
    rst = 0;
    chk("rst_mid_req", 32'(req), 32'd0);
    chk("rst_mid_err", 32'(bus_err), 32'd0);
    cyc(0, 2'b00, 0, 0, 0);
    chk("rst_mid_err2", 32'(bus_err), 32'd0);
    cyc(1, 2'b01, 32'h0000_7001, 32'h0000_0055, 0);
    chk("post_rst_wen", 32'(wen), 32'h2);
    cyc(0, 2'b00, 0, 0, 1);
    chk("post_rst_cnt", 32'(store_cnt), 32'd1);
    for (int k = 0; k < 600; k++) begin
      rst = $urandom_range(0, 99) < 2;
      cyc($urandom_range(0, 9) < 7, 2'($urandom), $urandom, $urandom, $urandom_range(0, 9) < 3);
    end
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
